// File: rtl/bk_addsub_pipe.sv
// rtl/bk_addsub_pipe.sv - pipelined Brent-Kung adder/subtractor with valid/ready handshake
//
// Purpose:
//   ALU add/sub path. Operands are split into GROUPSIZE-bit carry groups.
//   Step A forms the effective B operand, carry-in and group propagate/generate.
//   Step B resolves group carries with a Brent-Kung prefix tree (up-sweep then down-sweep).
//   Step C ripples inside each group to form sum bits, carry-out, signed overflow and zero.
//   Register Sa follows step A (PIPE_STAGES=3 only). Register Sb follows step B
//   (PIPE_STAGES>=2). Register Sc is the output register and is always present.
//   Each register stage has its own valid bit. A stage can load when it is empty
//   or when the stage after it is draining, so bubbles collapse and one result
//   can issue per cycle.
//
// Parameters:
//   WIDTH        operand width; must be a multiple of GROUPSIZE
//   GROUPSIZE    bits per carry group; WIDTH/GROUPSIZE must be a power of two >= 2
//   PIPE_STAGES  register stages, 1..3
//   TAG_W        sideband tag width, >= 1
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input transaction valid
//   in_ready   out  block can accept an input this cycle
//   in_a       in   operand A [WIDTH]
//   in_b       in   operand B [WIDTH]
//   in_cin     in   carry-in (add) / borrow-in (sub)
//   in_sub     in   0 = add, 1 = subtract
//   in_tag     in   sideband tag [TAG_W], returned unchanged
//   in_sat     in   saturate on signed overflow (only with BK_ADDSUB_SAT_EN)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out_sum    out  result [WIDTH]
//   out_cout   out  carry-out of MSB; in sub mode 1 = no borrow
//   out_ovf    out  signed overflow
//   out_zero   out  out_sum == 0
//   out_tag    out  tag of this result [TAG_W]
//
// Optional feature macro: BK_ADDSUB_SAT_EN
//   Defined: adds in_sat; a saturating op that overflows clamps to the largest
//   positive or most negative value. Undefined: the saturate flag is tied low
//   and results always wrap.

module bk_addsub_pipe #(
  parameter int WIDTH       = 32,
  parameter int GROUPSIZE   = 4,
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
`ifdef BK_ADDSUB_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG     = WIDTH / GROUPSIZE;
  localparam int LOG_NG = (NG > 1) ? $clog2(NG) : 1;

  // Elaboration-time parameter checks
  generate
    if ((GROUPSIZE < 1) || ((WIDTH % GROUPSIZE) != 0)) begin : g_bad_width
      $error("bk_addsub_pipe: WIDTH must be a multiple of GROUPSIZE");
    end
    if ((NG < 2) || ((NG & (NG - 1)) != 0)) begin : g_bad_groups
      $error("bk_addsub_pipe: WIDTH/GROUPSIZE must be a power of two, at least 2");
    end
    if ((PIPE_STAGES < 1) || (PIPE_STAGES > 3)) begin : g_bad_stages
      $error("bk_addsub_pipe: PIPE_STAGES must be 1, 2 or 3");
    end
    if (TAG_W < 1) begin : g_bad_tag
      $error("bk_addsub_pipe: TAG_W must be at least 1");
    end
  endgenerate

  // Saturate request; tied low when the feature is compiled out
  logic sat_in;
`ifdef BK_ADDSUB_SAT_EN
  assign sat_in = in_sat;
`else
  assign sat_in = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Step A: effective operand, carry-in, group propagate/generate
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] beff_d;
  logic             c0_d;
  logic [NG-1:0]    gp_d;
  logic [NG-1:0]    gg_d;

  always_comb begin : step_a
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             acc;
    beff_d = in_sub ? ~in_b : in_b;
    // Subtract is a + ~b + 1; a borrow-in removes that +1.
    c0_d   = in_cin ^ in_sub;
    p      = in_a ^ beff_d;
    g      = in_a & beff_d;
    gp_d   = '0;
    gg_d   = '0;
    for (int i = 0; i < NG; i++) begin
      gp_d[i] = &p[i*GROUPSIZE +: GROUPSIZE];
      acc     = 1'b0;
      for (int j = 0; j < GROUPSIZE; j++) begin
        acc = g[i*GROUPSIZE + j] | (p[i*GROUPSIZE + j] & acc);
      end
      gg_d[i] = acc;
    end
  end

  // Sa stage view (registered or bypassed)
  logic             sa_valid;
  logic             sa_rdy;
  logic [WIDTH-1:0] sa_a;
  logic [WIDTH-1:0] sa_beff;
  logic             sa_c0;
  logic [NG-1:0]    sa_gp;
  logic [NG-1:0]    sa_gg;
  logic [TAG_W-1:0] sa_tag;
  logic             sa_sat;

  logic             sb_rdy;

  generate
    if (PIPE_STAGES == 3) begin : g_sa
      logic             va_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] beff_q;
      logic             c0_q;
      logic [NG-1:0]    gp_q;
      logic [NG-1:0]    gg_q;
      logic [TAG_W-1:0] tag_q;
      logic             sat_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          va_q   <= 1'b0;
          a_q    <= '0;
          beff_q <= '0;
          c0_q   <= 1'b0;
          gp_q   <= '0;
          gg_q   <= '0;
          tag_q  <= '0;
          sat_q  <= 1'b0;
        end else if (sa_rdy) begin
          va_q <= in_valid;
          if (in_valid) begin
            a_q    <= in_a;
            beff_q <= beff_d;
            c0_q   <= c0_d;
            gp_q   <= gp_d;
            gg_q   <= gg_d;
            tag_q  <= in_tag;
            sat_q  <= sat_in;
          end
        end
      end

      assign sa_rdy   = !va_q || sb_rdy;
      assign sa_valid = va_q;
      assign sa_a     = a_q;
      assign sa_beff  = beff_q;
      assign sa_c0    = c0_q;
      assign sa_gp    = gp_q;
      assign sa_gg    = gg_q;
      assign sa_tag   = tag_q;
      assign sa_sat   = sat_q;
    end else begin : g_sa_bypass
      assign sa_rdy   = sb_rdy;
      assign sa_valid = in_valid;
      assign sa_a     = in_a;
      assign sa_beff  = beff_d;
      assign sa_c0    = c0_d;
      assign sa_gp    = gp_d;
      assign sa_gg    = gg_d;
      assign sa_tag   = in_tag;
      assign sa_sat   = sat_in;
    end
  endgenerate

  // in_ready depends only on stage valids and out_ready, never on in_valid.
  assign in_ready = sa_rdy;

  // ------------------------------------------------------------------
  // Step B: Brent-Kung prefix over groups, then fold in the carry-in
  // ------------------------------------------------------------------
  logic [NG:0] gc_d;   // gc_d[i] = carry into group i, gc_d[NG] = carry-out

  always_comb begin : step_b
    logic [NG-1:0] pg;
    logic [NG-1:0] pp;
    pg = sa_gg;
    pp = sa_gp;
    // Up-sweep: node i (i+1 a multiple of 2^(d+1)) absorbs the span 2^d below it.
    for (int d = 0; d < LOG_NG; d++) begin
      for (int i = (1 << (d + 1)) - 1; i < NG; i += (1 << (d + 1))) begin
        pg[i] = pg[i] | (pp[i] & pg[i - (1 << d)]);
        pp[i] = pp[i] & pp[i - (1 << d)];
      end
    end
    // Down-sweep: fill the remaining nodes from the nearest complete prefix.
    for (int d = LOG_NG - 2; d >= 0; d--) begin
      for (int i = (1 << (d + 1)) + (1 << d) - 1; i < NG; i += (1 << (d + 1))) begin
        pg[i] = pg[i] | (pp[i] & pg[i - (1 << d)]);
        pp[i] = pp[i] & pp[i - (1 << d)];
      end
    end
    gc_d    = '0;
    gc_d[0] = sa_c0;
    for (int i = 0; i < NG; i++) begin
      gc_d[i + 1] = pg[i] | (pp[i] & sa_c0);
    end
  end

  // Sb stage view (registered or bypassed)
  logic             sb_valid;
  logic [WIDTH-1:0] sb_a;
  logic [WIDTH-1:0] sb_beff;
  logic [NG:0]      sb_gc;
  logic [TAG_W-1:0] sb_tag;
  logic             sb_sat;

  logic             sc_rdy;

  generate
    if (PIPE_STAGES >= 2) begin : g_sb
      logic             vb_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] beff_q;
      logic [NG:0]      gc_q;
      logic [TAG_W-1:0] tag_q;
      logic             sat_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vb_q   <= 1'b0;
          a_q    <= '0;
          beff_q <= '0;
          gc_q   <= '0;
          tag_q  <= '0;
          sat_q  <= 1'b0;
        end else if (sb_rdy) begin
          vb_q <= sa_valid;
          if (sa_valid) begin
            a_q    <= sa_a;
            beff_q <= sa_beff;
            gc_q   <= gc_d;
            tag_q  <= sa_tag;
            sat_q  <= sa_sat;
          end
        end
      end

      assign sb_rdy   = !vb_q || sc_rdy;
      assign sb_valid = vb_q;
      assign sb_a     = a_q;
      assign sb_beff  = beff_q;
      assign sb_gc    = gc_q;
      assign sb_tag   = tag_q;
      assign sb_sat   = sat_q;
    end else begin : g_sb_bypass
      assign sb_rdy   = sc_rdy;
      assign sb_valid = sa_valid;
      assign sb_a     = sa_a;
      assign sb_beff  = sa_beff;
      assign sb_gc    = gc_d;
      assign sb_tag   = sa_tag;
      assign sb_sat   = sa_sat;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Step C: in-group ripple, sum, flags, optional clamp
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;

  always_comb begin : step_c
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;      // carry into each bit
    logic             carry;
    p = sb_a ^ sb_beff;
    g = sb_a & sb_beff;
    c = '0;
    for (int i = 0; i < NG; i++) begin
      carry = sb_gc[i];
      for (int j = 0; j < GROUPSIZE; j++) begin
        c[i*GROUPSIZE + j] = carry;
        carry = g[i*GROUPSIZE + j] | (p[i*GROUPSIZE + j] & carry);
      end
    end
    cout_d = sb_gc[NG];
    ovf_d  = c[WIDTH-1] ^ sb_gc[NG];
    sum_d  = p ^ c;
    // Overflow implies both effective signs match, so A's sign picks the rail.
    if (sb_sat && ovf_d) begin
      sum_d = sb_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    zero_d = (sum_d == '0);
  end

  // ------------------------------------------------------------------
  // Sc: output register, always present
  // ------------------------------------------------------------------
  logic             vc_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [TAG_W-1:0] tag_q;

  assign sc_rdy = !vc_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vc_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      tag_q  <= '0;
    end else if (sc_rdy) begin
      vc_q <= sb_valid;
      if (sb_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        tag_q  <= sb_tag;
      end
    end
  end

  assign out_valid = vc_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_tag   = tag_q;

endmodule

// File: doc/bk_addsub_pipe.md
Name: bk_addsub_pipe

Overview:
- Pipelined, parametrised Brent-Kung adder/subtractor with a valid/ready handshake on both sides.
- Splits WIDTH into GROUPSIZE-bit groups, builds group propagate/generate, resolves group carries with a Brent-Kung prefix tree (up-sweep then down-sweep), and forms sums per group.
- Adds subtract mode, signed-overflow/zero flags, a sideband tag and 1–3 register stages.
- Serves as the ALU add/sub path in the CPU datapath.

Parameters:
- WIDTH, 32: operand width. Must be a multiple of GROUPSIZE.
- GROUPSIZE, 4: bits per carry group. WIDTH/GROUPSIZE must be a power of two, at least 2; otherwise elaboration fails via a generate-time error.
- PIPE_STAGES, 3: register stages, legal values 1..3. Any other value fails at elaboration.
- TAG_W, 4: sideband tag width, at least 1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (add) / borrow-in (sub)
- in_sub  in  1  0 = add, 1 = subtract
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry-out of MSB; in sub mode, 1 = no borrow
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_sum == 0
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Arithmetic:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_cin ^ in_sub.
  - {out_cout, out_sum} = in_a + b_eff + c0, computed modulo 2^WIDTH with carry.
  - Sub with in_cin=0 gives a−b; sub with in_cin=1 gives a−b−1.
  - out_ovf = carry into MSB XOR carry out of MSB.
- Stage boundaries:
  - Sa: after b_eff/c0 and group propagate/generate.
  - Sb: after prefix-tree group carries.
  - Sc: output register, always present.
  - PIPE_STAGES=1 uses Sc only; 2 uses Sb and Sc; 3 uses Sa, Sb and Sc.
- Latency: an input accepted in cycle T appears with out_valid=1 in cycle T+PIPE_STAGES when not stalled.
- Capacity and throughput: capacity is PIPE_STAGES transactions; throughput is 1 per cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Each stage k has valid_k.
  - ready_last = out_ready.
  - ready_k = !valid_k || ready_{k+1}; bubbles collapse.
  - in_ready = ready of the first stage. It is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - out_valid is high only when the last stage holds data.
  - While out_valid && !out_ready, all out_* hold stable.
  - Data and tag move with their valid bit. Results leave in acceptance order, with no loss or duplication.
- Reset:
  - On rst_n low, every valid_k clears immediately (asynchronous), so out_valid=0.
  - out_sum, out_cout, out_ovf, out_zero and out_tag reset to 0.
  - Internal data registers reset to 0.
  - In-flight transactions are discarded. After rst_n rises, no stale result is emitted.
- Boundaries:
  - Pipeline full with out_ready=0: in_ready=0.
  - Full with out_ready=1: accept and emit in the same cycle.
  - Empty: out_valid=0; in_ready=1.
  - in_valid with X operands while in_ready=0: no effect.

Optional Feature:
- Macro: BK_ADDSUB_SAT_EN.
- When defined:
  - Extra input port in_sat (1 bit) is added and carried down the pipeline.
  - If in_sat=1 and overflow occurs, out_sum clamps to 0x7F..F for positive overflow (operands' effective signs both 0) or 0x80..0 for negative overflow.
  - out_ovf still reports 1, and out_zero reflects the clamped value.
- When undefined: the port is absent and results always wrap.

Test Plan (WIDTH=32, GROUPSIZE=4, PIPE_STAGES=3, out_ready=1 unless stated):
- Add carry wrap: add 0xFFFFFFFF+0x00000001, cin=0, tag=0x3 → 3 cycles later: sum=0x00000000, cout=1, zero=1, ovf=0, tag=0x3.
- Signed overflow: add 0x7FFFFFFF+0x00000001 → sum=0x80000000, ovf=1, cout=0. With BK_ADDSUB_SAT_EN and in_sat=1 → sum=0x7FFFFFFF, ovf=1.
- Subtract: sub 5−7, cin=0 → 0xFFFFFFFE, cout=0, ovf=0. Sub 0x80000000−1 → 0x7FFFFFFF, ovf=1, cout=1. Sub 9−4 with cin=1 → 0x00000004.
- Backpressure: stream tags 0..7 back-to-back while out_ready is held 0 for 5 cycles → exactly 3 accepted before in_ready=0. After release, tags emerge 0..7 in order, one per cycle, no gaps.
- Reset mid-operation: 2 transactions in flight, pulse rst_n low asynchronously mid-cycle → out_valid=0 and all outputs 0 immediately. After release, no output until new input.
- Randomised sweep: 10k random ops against a behavioural model for PIPE_STAGES 1/2/3, GROUPSIZE 2/4/8 and random out_ready → zero mismatches and 1 result per cycle when out_ready is held 1.
